// File: rtl/tl_d_channel_arbiter_if.sv
// D-channel bundle between NumIn upstream responders and the merged core-side D channel,
// plus the arbiter's status outputs.
interface tl_d_channel_arbiter_if #(
  parameter int unsigned NumIn = 2
);
  logic [NumIn-1:0]    in_valid;
  logic [NumIn-1:0]    in_ready;
  logic [3*NumIn-1:0]  in_opcode;
  logic [2*NumIn-1:0]  in_param;
  logic [4*NumIn-1:0]  in_size;
  logic [NumIn-1:0]    in_source;
  logic [NumIn-1:0]    in_sink;
  logic [NumIn-1:0]    in_denied;
  logic [NumIn-1:0]    in_corrupt;
  logic [32*NumIn-1:0] in_data;

  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic        d_source;
  logic        d_sink;
  logic        d_denied;
  logic        d_corrupt;
  logic [31:0] d_data;

  logic        busy;
  logic [1:0]  grant_idx;
  logic        err_size;

  // Responder/core side.
  modport master (
    output in_valid, in_opcode, in_param, in_size, in_source, in_sink, in_denied, in_corrupt,
           in_data, d_ready,
    input  in_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt,
           d_data, busy, grant_idx, err_size
  );

  // Arbiter side.
  modport slave (
    input  in_valid, in_opcode, in_param, in_size, in_source, in_sink, in_denied, in_corrupt,
           in_data, d_ready,
    output in_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt,
           d_data, busy, grant_idx, err_size
  );
endinterface

// File: rtl/tl_d_channel_arbiter.sv
// Round-robin merge of NumIn TileLink D channels into one; multi-beat data responses hold
// the grant until their last beat so bursts never interleave. Datapath is pure muxing.
module tl_d_channel_arbiter #(
  parameter int unsigned NumIn     = 2,
  parameter int unsigned MaxLgSize = 6
) (
  input logic                  clock,
  input logic                  reset,
  tl_d_channel_arbiter_if.slave bus
);
  localparam int unsigned CntW = MaxLgSize - 1;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state_q, state_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [1:0]      grant_q;
  logic [CntW-1:0] beats_left_q, beats_left_d;
  logic            err_q, err_d;
  logic            stall_q, stall_d;

  logic            found, held_valid, fire, oversize, is_data;
  logic [1:0]      winner, grant;
  logic [3:0]      eff_size;
  logic [CntW-1:0] beats;

  function automatic logic [1:0] inc_idx(logic [1:0] x);
    return (32'(x) == NumIn - 1) ? 2'd0 : x + 2'd1;
  endfunction

  // First valid input at or after rr_ptr, wrapping modulo NumIn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned off = 0; off < NumIn; off++) begin
      for (int unsigned j = 0; j < NumIn; j++) begin
        if (!found && bus.in_valid[j] && (j == (32'(rr_ptr_q) + off) % NumIn)) begin
          found  = 1'b1;
          winner = 2'(j);
        end
      end
    end
  end

  always_comb begin
    held_valid = 1'b0;
    for (int unsigned j = 0; j < NumIn; j++) begin
      if (grant_q == 2'(j)) held_valid = bus.in_valid[j];
    end
  end

  // A beat stalled by d_ready keeps its grant even if a closer input becomes valid.
  always_comb begin
    if (state_q == StBurst)         grant = grant_q;
    else if (stall_q && held_valid) grant = grant_q;
    else if (found)                 grant = winner;
    else                            grant = grant_q;
  end

  always_comb begin
    bus.d_valid   = 1'b0;
    bus.d_opcode  = '0;
    bus.d_param   = '0;
    bus.d_size    = '0;
    bus.d_source  = 1'b0;
    bus.d_sink    = 1'b0;
    bus.d_denied  = 1'b0;
    bus.d_corrupt = 1'b0;
    bus.d_data    = '0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      if (grant == 2'(i)) begin
        bus.d_valid   = bus.in_valid[i];
        bus.d_opcode  = bus.in_opcode[3*i +: 3];
        bus.d_param   = bus.in_param[2*i +: 2];
        bus.d_size    = bus.in_size[4*i +: 4];
        bus.d_source  = bus.in_source[i];
        bus.d_sink    = bus.in_sink[i];
        bus.d_denied  = bus.in_denied[i];
        bus.d_corrupt = bus.in_corrupt[i];
        bus.d_data    = bus.in_data[32*i +: 32];
      end
    end
    bus.in_ready = '0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      bus.in_ready[i] = bus.d_ready & bus.d_valid & (grant == 2'(i));
    end
  end

  assign fire          = bus.d_valid & bus.d_ready;
  assign is_data       = (bus.d_opcode == 3'd1) || (bus.d_opcode == 3'd5);
  assign oversize      = bus.d_size > 4'(MaxLgSize);
  assign eff_size      = oversize ? 4'(MaxLgSize) : bus.d_size;
  assign beats         = (is_data && eff_size > 4'd2) ? (CntW'(1) << (eff_size - 4'd2)) : CntW'(1);
  assign bus.busy      = (state_q == StBurst);
  assign bus.grant_idx = grant;
  assign bus.err_size  = err_q;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    beats_left_d = beats_left_q;
    err_d        = err_q;
    stall_d      = (state_q == StIdle) & bus.d_valid & ~bus.d_ready;
    unique case (state_q)
      StIdle: begin
        if (fire) begin
          if (oversize) err_d = 1'b1;
          if (beats == CntW'(1)) begin
            rr_ptr_d = inc_idx(grant);
          end else begin
            state_d      = StBurst;
            beats_left_d = beats - CntW'(1);
          end
        end
      end
      StBurst: begin
        if (fire) begin
          beats_left_d = beats_left_q - CntW'(1);
          if (beats_left_q == CntW'(1)) begin
            state_d  = StIdle;
            rr_ptr_d = inc_idx(grant_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      beats_left_q <= '0;
      err_q        <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant;
      beats_left_q <= beats_left_d;
      err_q        <= err_d;
      stall_q      <= stall_d;
    end
  end
endmodule

// File: doc/tl_d_channel_arbiter.md
Name: tl_d_channel_arbiter

Overview:
- Round-robin arbiter that merges NUM_IN TileLink D-channel response streams into the single hart-0 data D channel: 32-bit data, 1-bit source, 1-bit sink.
- Locks the grant for the full duration of a multi-beat data response, so beats from different responders never interleave.
- Sits between the memory-side responders (e.g. tightly-integrated memory and system-port bridge) and the core's data D-channel input.
- Zero-latency pass-through datapath. State is limited to the round-robin pointer, the lock/beat counter and the sticky error flag.

Parameters:
- NUM_IN, 2, number of upstream D-channel responders (2..4).
- MAX_LG_SIZE, 6, largest legal log2 transfer size in bytes; 6 means 64 B, i.e. 16 beats.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  NUM_IN  per-responder beat valid.
- in_ready  out  NUM_IN  per-responder beat accepted.
- in_opcode  in  3*NUM_IN  D opcode, packed, index i at [3i+:3].
- in_param  in  2*NUM_IN  D param.
- in_size  in  4*NUM_IN  log2 bytes.
- in_source  in  NUM_IN  source id.
- in_sink  in  NUM_IN  sink id.
- in_denied  in  NUM_IN  denied flag.
- in_corrupt  in  NUM_IN  corrupt flag.
- in_data  in  32*NUM_IN  beat data.
- d_valid  out  1  merged beat valid.
- d_ready  in  1  core accepts beat.
- d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data  out  3/2/4/1/1/1/1/32  muxed fields of the granted input.
- busy  out  1  lock held; a burst is mid-flight.
- grant_idx  out  2  currently selected input.
- err_size  out  1  sticky flag: size above MAX_LG_SIZE was seen.

Behaviour:
- Reset (synchronous): rr_ptr=0, locked=0, beats_left=0, err_size=0.
  - busy=0, grant_idx=0 after reset.
  - d_valid follows the inputs combinationally: 0 when no in_valid is set.
- Beat fire: d_valid & d_ready.
- Beat count per message:
  - Data opcodes are AccessAckData (1) and GrantData (5).
  - Data opcode with size>2: beats = 2^(size-2).
  - Any other case: beats = 1.
  - Size > MAX_LG_SIZE: beats = 2^(MAX_LG_SIZE-2), and err_size is set until reset.
- State IDLE (locked=0):
  - Grant goes to the first asserted in_valid, searching from rr_ptr upward modulo NUM_IN.
  - grant_idx = winner, or holds its last value if no input is valid.
  - A fire with beats==1: rr_ptr <= winner+1 mod NUM_IN; stay IDLE.
  - A fire with beats>1: locked <= 1, beats_left <= beats-1, go to BURST.
- State BURST (locked=1):
  - Grant is fixed to grant_idx; other inputs' valids are ignored.
  - Each fire decrements beats_left.
  - A fire with beats_left==1: locked <= 0, rr_ptr <= grant_idx+1 mod NUM_IN, return to IDLE.
  - Granted valid low during a burst: d_valid=0, lock is held, no timeout.
- Handshake and muxing:
  - in_ready[i] = d_ready & (i == grant) & d_valid.
  - Non-granted in_ready are 0.
  - All d_* fields are muxed from the granted input.
  - No combinational path from any in_valid to any in_ready other than through the grant.
- Ordering: a responder stalled by d_ready=0 keeps its grant. Arbitration is not re-evaluated until a fire occurs or valid drops in IDLE.
- Reset mid-burst clears the lock immediately; the next cycle arbitrates from index 0.
- Out-of-range grant_idx: upper bits are zero when NUM_IN<4.

Test Plan:
- Two inputs both valid, single-beat AccessAck (opcode 0, size 2), d_ready=1 -> grants alternate 0,1,0,1 across 4 cycles; rr_ptr wraps correctly.
- Input0 AccessAckData size 4 (4 beats), input1 valid throughout -> 4 consecutive beats from input0 with busy=1 for beats 1-3, then input1 granted on cycle 5.
- Burst with d_ready toggling 1,0,1,0 -> in_ready[0] mirrors d_ready, no beat is lost or duplicated, and data order D0..D3 is preserved.
- Size 7 with MAX_LG_SIZE=6 on AccessAckData -> 16 beats transferred, err_size=1 and remains 1 until reset.
- Reset asserted after beat 2 of a 16-beat burst -> next cycle busy=0, rr_ptr=0, err_size=0; input1 wins if only input1 is valid.
- AccessAck (opcode 0) with size 6 -> treated as 1 beat, no lock taken, busy stays 0.
